fp_addsub_sched: RTL
====================

# fp_addsub_sched

Round-robin scheduler that shares one pipelined Fp add/sub datapath (the 3-stage split-carry adder/subtractor pair) among `N_REQ` requesters. Accepts one operation per cycle through per-requester valid/ready handshakes, registers operands and op-select into the datapath, tracks requester ID through a tag pipeline matched to the datapath latency, and returns tagged results. Sits between the pairing-arithmetic sequencers and the shared wide adder.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `W`, 272: operand width, equals `$bits(uint_fp_t)`.
- `LATENCY`, 3: datapath latency in cycles from `dp_valid` to `dp_z`/`dp_carry` (1..4).
- `ID_W`, `$clog2(N_REQ)`: requester ID width.

- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: leave IDLE and start granting.
- `flush` in 1: stop granting and drain in-flight operations.
- `req_valid` in N_REQ: per-requester operation valid.
- `req_ready` out N_REQ: per-requester accept (one-hot or zero).
- `req_x`, `req_y` in N_REQ*W: flattened operands, requester i at `[i*W +: W]`.
- `req_sub` in N_REQ: 1 = X − Y, 0 = X + Y.
- `dp_valid` out 1; `dp_x`, `dp_y` out W; `dp_sub` out 1: registered issue to datapath.
- `dp_z` in W; `dp_carry` in 1: datapath result, `LATENCY` cycles after issue.
- `rsp_valid` out 1; `rsp_id` out ID_W; `rsp_z` out W; `rsp_carry` out 1: registered result.
- `idle` out 1: high in IDLE with nothing in flight.

## Operation
- FSM states IDLE, RUN, DRAIN. Reset → IDLE.
- IDLE: no grants; `en`=1 → RUN.
- RUN: grant at most one requester per cycle; `flush`=1 → DRAIN (no grant in that cycle).
- DRAIN: no grants; in-flight count reaches 0 → IDLE. `en` ignored in DRAIN.
- Arbitration: round-robin; search starts at `last_grant+1` mod N_REQ; `last_grant` resets to N_REQ−1 (requester 0 wins first). Pointer updates only on a handshake.
- `req_ready[i]` combinational: high only for the selected requester when state is RUN and `flush`=0. Handshake = `req_valid[i] & req_ready[i]`. `req_ready` never depends on other requesters' `req_valid` beyond the arbitration itself.
- On handshake, next cycle: `dp_valid`=1, `dp_x/dp_y/dp_sub` = granted requester's values; otherwise `dp_valid`=0, operands hold.
- Tag pipeline: `LATENCY` stages of {valid, id}; aligned with `dp_z`.
- Response: when tag stage `LATENCY` valid, next cycle `rsp_valid`=1 with `rsp_id`, `rsp_z`=`dp_z`, `rsp_carry`=`dp_carry`. No backpressure on responses.
- Subtraction carry semantics belong to datapath: `rsp_carry`=1 means no borrow.
- In-flight counter: +1 on handshake, −1 on `rsp_valid`; simultaneous → unchanged; max `LATENCY+2`, width `$clog2(LATENCY+3)`.
- `idle` = (state==IDLE) & (in-flight==0).

## Timing
- Reset values: `req_ready`=0, `dp_valid`=0, `dp_x`=`dp_y`=0, `dp_sub`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_z`=0, `rsp_carry`=0, `idle`=1, tag valids 0, counter 0.
- Handshake in cycle t → `dp_valid` t+1 → `rsp_valid` t+2+LATENCY (5 cycles at LATENCY=3).
- Throughput: 1 op/cycle sustained, no bubbles between back-to-back grants.
- `flush` and `en` sampled on the edge; `flush` with zero in-flight: RUN → DRAIN → IDLE (1 cycle in DRAIN).
- Reset asserted mid-operation: all in-flight tags discarded, no `rsp_valid` after release for pre-reset ops.

## Configuration
- `FP_ADDSUB_SCHED_STATS_EN`: defined → adds output `stat_grants` (N_REQ*32), per-requester saturating 32-bit grant counters, reset to 0, incremented on each handshake, hold at 0xFFFF_FFFF. Undefined → port and counters absent; all other behaviour identical.

## Test plan
- Single add: after `en`, requester 2 issues x=5, y=7, sub=0 at cycle t → `rsp_valid` at t+5, `rsp_id`=2, `rsp_z`=12, `rsp_carry`=0 (LATENCY=3, behavioural datapath).
- Single sub: requester 0, x=3, y=5, sub=1 → `rsp_z`=2^W−2, `rsp_carry`=0; x=5, y=3 → `rsp_z`=2, `rsp_carry`=1.
- Fairness: all four `req_valid` held high 12 cycles → grants 0,1,2,3,0,1,2,3,…; responses in same order, one per cycle, IDs match.
- Flush: 3 ops in flight, assert `flush` → `req_ready`=0 immediately, 3 responses delivered, then IDLE, `idle`=1.
- Reset mid-flight: 2 ops issued, `rst_n` low 1 cycle → all outputs at reset values, no responses after release, `idle`=1.
- Stats (macro defined): 10 grants to requester 1 → `stat_grants[32 +: 32]`=10, others 0.

Source files
------------

// File: rtl/fp_addsub_sched.sv
// Round-robin scheduler sharing one pipelined add/sub datapath among N_REQ requesters; tags track requester ID.
// Issue 1 cycle after handshake, response LATENCY+2 after handshake; optional grant counters via FP_ADDSUB_SCHED_STATS_EN.
module fp_addsub_sched #(
   parameter int N_REQ   = 4,
   parameter int W       = 272,
   parameter int LATENCY = 3,
   parameter int ID_W    = $clog2(N_REQ)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                flush,
   input  logic [N_REQ-1:0]    req_valid,
   output logic [N_REQ-1:0]    req_ready,
   input  logic [N_REQ*W-1:0]  req_x,
   input  logic [N_REQ*W-1:0]  req_y,
   input  logic [N_REQ-1:0]    req_sub,
   output logic                dp_valid,
   output logic [W-1:0]        dp_x,
   output logic [W-1:0]        dp_y,
   output logic                dp_sub,
   input  logic [W-1:0]        dp_z,
   input  logic                dp_carry,
   output logic                rsp_valid,
   output logic [ID_W-1:0]     rsp_id,
   output logic [W-1:0]        rsp_z,
   output logic                rsp_carry,
   output logic                idle
`ifdef FP_ADDSUB_SCHED_STATS_EN
   ,
   output logic [N_REQ*32-1:0] stat_grants
`endif
);

   localparam int CNT_W = $clog2(LATENCY + 3);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]      r_state;
   logic [ID_W-1:0] r_last;
   logic [CNT_W-1:0] r_cnt;

   logic            r_dp_valid;
   logic [W-1:0]    r_dp_x;
   logic [W-1:0]    r_dp_y;
   logic            r_dp_sub;
   logic [ID_W-1:0] r_dp_id;

   logic [LATENCY-1:0] r_tag_vld;
   logic [ID_W-1:0]    r_tag_id [LATENCY];

   logic            r_rsp_valid;
   logic [ID_W-1:0] r_rsp_id;
   logic [W-1:0]    r_rsp_z;
   logic            r_rsp_carry;

   logic            w_found;
   logic [ID_W-1:0] w_sel;
   logic            w_grant_en;
   logic            w_hs;

   // Wrap pass (k <= last) is overridden by the pass above last, so the search starts at last+1.
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req_valid[k] && (k <= int'(r_last))) begin
            w_found = 1'b1;
            w_sel   = ID_W'(k);
         end
      end
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req_valid[k] && (k > int'(r_last))) begin
            w_found = 1'b1;
            w_sel   = ID_W'(k);
         end
      end
   end

   assign w_grant_en = (r_state == S_RUN) && !flush;
   assign w_hs       = w_grant_en && w_found;

   always_comb begin
      req_ready = '0;
      if (w_hs) begin
         req_ready[w_sel] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (en)            r_state <= S_RUN;
            S_RUN:   if (flush)         r_state <= S_DRAIN;
            S_DRAIN: if (r_cnt == '0)   r_state <= S_IDLE;
            default:                    r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last     <= ID_W'(N_REQ - 1);
         r_dp_valid <= 1'b0;
         r_dp_x     <= '0;
         r_dp_y     <= '0;
         r_dp_sub   <= 1'b0;
         r_dp_id    <= '0;
      end else begin
         r_dp_valid <= w_hs;
         if (w_hs) begin
            r_last   <= w_sel;
            r_dp_x   <= req_x[w_sel*W +: W];
            r_dp_y   <= req_y[w_sel*W +: W];
            r_dp_sub <= req_sub[w_sel];
            r_dp_id  <= w_sel;
         end
      end
   end

   // Tag stage LATENCY-1 lines up with dp_z for the same operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tag_vld <= '0;
         for (int k = 0; k < LATENCY; k++) begin
            r_tag_id[k] <= '0;
         end
      end else begin
         r_tag_vld[0] <= r_dp_valid;
         r_tag_id[0]  <= r_dp_id;
         for (int k = 1; k < LATENCY; k++) begin
            r_tag_vld[k] <= r_tag_vld[k-1];
            r_tag_id[k]  <= r_tag_id[k-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_z     <= '0;
         r_rsp_carry <= 1'b0;
      end else begin
         r_rsp_valid <= r_tag_vld[LATENCY-1];
         if (r_tag_vld[LATENCY-1]) begin
            r_rsp_id    <= r_tag_id[LATENCY-1];
            r_rsp_z     <= dp_z;
            r_rsp_carry <= dp_carry;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else begin
         case ({w_hs, r_rsp_valid})
            2'b10:   r_cnt <= r_cnt + CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

`ifdef FP_ADDSUB_SCHED_STATS_EN
   for (genvar g = 0; g < N_REQ; g++) begin : g_stat
      logic [31:0] r_grants;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_grants <= '0;
         end else if (w_hs && (w_sel == ID_W'(g)) && (r_grants != 32'hFFFF_FFFF)) begin
            r_grants <= r_grants + 32'd1;
         end
      end
      assign stat_grants[g*32 +: 32] = r_grants;
   end
`endif

   assign dp_valid  = r_dp_valid;
   assign dp_x      = r_dp_x;
   assign dp_y      = r_dp_y;
   assign dp_sub    = r_dp_sub;
   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_z     = r_rsp_z;
   assign rsp_carry = r_rsp_carry;
   assign idle      = (r_state == S_IDLE) && (r_cnt == '0);

endmodule
